// File: rtl/simple_fpga_cvs_pkg.sv
// Shared constants for the simple FPGA CVS bring-up block.
// The blink rate is 1.2 Hz, held as the ratio 12/10 so that every
// derived value stays in integer arithmetic.
package simple_fpga_cvs_pkg;

  localparam int OSC_HZ       = 300_000_000;
  localparam int BLINK_HZ_NUM = 12;
  localparam int BLINK_HZ_DEN = 10;

  // OSC_HZ / (2 * 1.2), ordered so no intermediate value overflows a 32-bit int
  localparam int HALF_PERIOD_DEFAULT = ((OSC_HZ / 2) * BLINK_HZ_DEN) / BLINK_HZ_NUM;

  // Narrowest counter width that still holds HALF_PERIOD_DEFAULT-1
  localparam int CNT_W_DEFAULT = $clog2(HALF_PERIOD_DEFAULT);

endpackage

// File: rtl/simple_fpga_cvs_if.sv
// Bundle of board-side switch inputs and LED/pin outputs.
// The master side drives the switches; the slave side (the board logic)
// drives the LEDs and the blink output.
interface simple_fpga_cvs_if;

  logic sw [4:0];
  logic in0;
  logic in0_and_in1;
  logic in0_or_in1;
  logic not_in2;
  logic blink;

  modport master (
    output sw,
    input  in0, in0_and_in1, in0_or_in1, not_in2, blink
  );

  modport slave (
    input  sw,
    output in0, in0_and_in1, in0_or_in1, not_in2, blink
  );

endinterface

// File: rtl/simple_fpga_cvs_clk_divider.sv
// Square-wave divider: clk_out toggles once every HALF_PERIOD rising
// edges of clk, giving a 50% duty output of period 2*HALF_PERIOD.
// The count never exceeds HALF_PERIOD-1, so there is no natural wrap.
module clk_divider
  import simple_fpga_cvs_pkg::*;
#(
  parameter int HALF_PERIOD = HALF_PERIOD_DEFAULT,
  parameter int CNT_W       = CNT_W_DEFAULT
) (
  input  logic clk,
  input  logic reset_n,
  output logic clk_out
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(HALF_PERIOD - 1);

  logic [CNT_W-1:0] cnt;

  // Count osc edges; on the last one of a half-period, restart and flip the output
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt     <= '0;
      clk_out <= 1'b0;
    end else if (cnt == LAST) begin
      cnt     <= '0;
      clk_out <= ~clk_out;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/simple_fpga_cvs_top.sv
// Bring-up top for the simple FPGA CVS board: switch-to-LED gates with
// no registers in the path, plus a ~1.2 Hz blink derived from the
// 300 MHz differential oscillator. In behavioural RTL only the P leg
// is used as the clock; synthesis maps the pair to the vendor
// differential clock buffer. The blink output is a fabric signal and
// nothing here is clocked by it.
module simple_fpga_cvs_top #(
  parameter int OSC_HZ      = simple_fpga_cvs_pkg::OSC_HZ,
  parameter int HALF_PERIOD = simple_fpga_cvs_pkg::HALF_PERIOD_DEFAULT,
  parameter int CNT_W       = simple_fpga_cvs_pkg::CNT_W_DEFAULT
) (
  input  logic [1:0] osc_300_pn,
  input  logic       reset_n,
  input  logic       in [4:0],
  output logic       in0_out,
  output logic       in0_and_in1_out,
  output logic       in0_or_in1_out,
  output logic       not_in2_out,
  output logic       clk_1point2hz
);

  import simple_fpga_cvs_pkg::*;

  // OSC_HZ is informational only; in[3], in[4] and the N leg are reserved
  localparam int unused_osc_hz = OSC_HZ;
  logic unused_pins;
  assign unused_pins = &{1'b0, osc_300_pn[1], in[3], in[4]};

  logic clk_osc;
  assign clk_osc = osc_300_pn[0];

  // Switch-to-LED gates, pure functions of in[2:0], independent of clock and reset
  always_comb begin
    in0_out         = in[0];
    in0_and_in1_out = in[0] & in[1];
    in0_or_in1_out  = in[0] | in[1];
    not_in2_out     = ~in[2];
  end

  clk_divider #(
    .HALF_PERIOD (HALF_PERIOD),
    .CNT_W       (CNT_W)
  ) u_clk_divider (
    .clk     (clk_osc),
    .reset_n (reset_n),
    .clk_out (clk_1point2hz)
  );

endmodule

// File: tb/tb_simple_fpga_cvs_top.sv
// Directed bench for simple_fpga_cvs_top with a shortened divider
// (HALF_PERIOD=4) and a second instance built with HALF_PERIOD=1.
`timescale 1ps/1ps
module tb_simple_fpga_cvs_top;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int n_compared = 0;
  int n_mismatched = 0;

  simple_fpga_cvs_if io ();
  simple_fpga_cvs_if io_fast ();

  // 3333 ps oscillator, N leg is the complement of P
  always begin
    #1667 clk = 1'b1;
    #1666 clk = 1'b0;
  end

  simple_fpga_cvs_top #(.HALF_PERIOD(4), .CNT_W(3)) dut (
    .osc_300_pn      ({~clk, clk}),
    .reset_n         (reset_n),
    .in              (io.sw),
    .in0_out         (io.in0),
    .in0_and_in1_out (io.in0_and_in1),
    .in0_or_in1_out  (io.in0_or_in1),
    .not_in2_out     (io.not_in2),
    .clk_1point2hz   (io.blink)
  );

  simple_fpga_cvs_top #(.HALF_PERIOD(1), .CNT_W(1)) dut_fast (
    .osc_300_pn      ({~clk, clk}),
    .reset_n         (reset_n),
    .in              (io_fast.sw),
    .in0_out         (io_fast.in0),
    .in0_and_in1_out (io_fast.in0_and_in1),
    .in0_or_in1_out  (io_fast.in0_or_in1),
    .not_in2_out     (io_fast.not_in2),
    .clk_1point2hz   (io_fast.blink)
  );

  task automatic set_sw(input logic [4:0] v);
    for (int i = 0; i < 5; i++) io.sw[i] = v[i];
  endtask

  task automatic check_gates(input string name, input logic [2:0] v);
    logic [3:0] got;
    logic [3:0] exp;
    #1;
    got = {io.in0, io.in0_and_in1, io.in0_or_in1, io.not_in2};
    exp = {v[0], v[0] & v[1], v[0] | v[1], ~v[2]};
    n_compared++;
    if (got !== exp) begin
      n_mismatched++;
      $display("[TB] FAIL %s in=%b got=%b expected=%b", name, v, got, exp);
    end
  endtask

  // Assert reset between edges, then release just after a falling edge
  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    #100;
    n_compared++;
    if (io.blink !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_blink got=%b expected=0", io.blink);
    end
    n_compared++;
    if (io_fast.blink !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_fast_blink got=%b expected=0", io_fast.blink);
    end
  endtask

  task automatic test_truth_table();
    for (int v = 0; v < 8; v++) begin
      set_sw({2'b00, 3'(v)});
      check_gates("truth_table", 3'(v));
    end
  endtask

  task automatic test_reserved_inputs();
    for (int r = 0; r < 4; r++) begin
      set_sw({2'(r), 3'b001});
      check_gates("reserved_ignored", 3'b001);
    end
  endtask

  task automatic test_divider();
    logic exp;
    do_reset();
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      @(negedge clk);
      exp = ((k / 4) % 2) == 1;
      n_compared++;
      if (io.blink !== exp) begin
        n_mismatched++;
        $display("[TB] FAIL divider_edge%0d got=%b expected=%b", k, io.blink, exp);
      end
    end
  endtask

  task automatic test_reset_mid_count();
    logic exp;
    do_reset();
    repeat (6) @(posedge clk);
    @(negedge clk);
    n_compared++;
    if (io.blink !== 1'b1) begin
      n_mismatched++;
      $display("[TB] FAIL midreset_pre got=%b expected=1", io.blink);
    end
    #200;
    reset_n = 1'b0;
    #10;
    n_compared++;
    if (io.blink !== 1'b0) begin
      n_mismatched++;
      $display("[TB] FAIL midreset_async got=%b expected=0", io.blink);
    end
    @(negedge clk);
    reset_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge clk);
      @(negedge clk);
      exp = (k >= 4);
      n_compared++;
      if (io.blink !== exp) begin
        n_mismatched++;
        $display("[TB] FAIL midreset_edge%0d got=%b expected=%b", k, io.blink, exp);
      end
    end
  endtask

  task automatic test_half_period_one();
    logic exp;
    do_reset();
    for (int k = 1; k <= 6; k++) begin
      @(posedge clk);
      @(negedge clk);
      exp = (k % 2) == 1;
      n_compared++;
      if (io_fast.blink !== exp) begin
        n_mismatched++;
        $display("[TB] FAIL fast_edge%0d got=%b expected=%b", k, io_fast.blink, exp);
      end
    end
  endtask

  task automatic test_gates_during_reset();
    logic [2:0] pattern [6];
    pattern = '{3'b011, 3'b100, 3'b101, 3'b010, 3'b111, 3'b000};
    @(negedge clk);
    reset_n = 1'b0;
    for (int i = 0; i < 6; i++) begin
      set_sw({2'b10, pattern[i]});
      check_gates("gates_in_reset", pattern[i]);
      @(negedge clk);
    end
    reset_n = 1'b1;
  endtask

  initial begin
    set_sw(5'b00000);
    for (int i = 0; i < 5; i++) io_fast.sw[i] = 1'b0;
    test_reset();
    test_truth_table();
    test_reserved_inputs();
    test_divider();
    test_reset_mid_count();
    test_half_period_one();
    test_gates_during_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
